fpm_rr_scheduler: RTL and testbench

//  Shares one combinational FPM (single-precision multiplier: a, b -> product, overflow)

---
 rtl/fpm_rr_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_fpm_rr_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_rr_scheduler.sv
// fpm_rr_scheduler: round-robin arbiter sharing one combinational binary32 multiplier among NUM_REQ requesters.
// Optional build macro FPM_ARB_ZERO_BYPASS_EN: zero operands skip the multiplier (1-cycle latency).

// Combinational binary32 multiply. It uses round-to-nearest-even. Denormal inputs and
// results flush to signed zero, and exponent overflow saturates to signed infinity with overflow=1.
module fpm_rr_scheduler_fpm (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        overflow
);

  // mn has its leading one at bit 47; the result mantissa is mn[47:24].
  function automatic logic [24:0] round_rne(input logic [47:0] mn);
    logic up;
    up = mn[23] & (mn[24] | (|mn[22:0]));
    return {1'b0, mn[47:24]} + {24'b0, up};
  endfunction

  logic              sign;
  logic [23:0]       ma;
  logic [23:0]       mb;
  logic [47:0]       mp;
  logic [47:0]       mn;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic signed [9:0] exp_sum;
  logic signed [9:0] exp_r;

  always_comb begin
    sign     = a[31] ^ b[31];
    ma       = {1'b1, a[22:0]};
    mb       = {1'b1, b[22:0]};
    mp       = {24'b0, ma} * {24'b0, mb};
    mn       = mp[47] ? mp : {mp[46:0], 1'b0};
    mant_r   = round_rne(mn);
    exp_sum  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    exp_r    = exp_sum + $signed({9'b0, mp[47]}) + $signed({9'b0, mant_r[24]});
    frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    product  = {sign, 31'b0};
    overflow = 1'b0;
    if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
      if (exp_r >= 10'sd255) begin
        product  = {sign, 8'hff, 23'b0};
        overflow = 1'b1;
      end else if (exp_r > 10'sd0) begin
        product = {sign, exp_r[7:0], frac};
      end
    end
  end

endmodule

module fpm_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_product,
  output logic                  resp_overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] ptr_next;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            zero_hit;
  logic [31:0]     op_a_p0;
  logic [31:0]     op_b_p0;
  logic [ID_W-1:0] op_id_p0;
  logic [31:0]     fpm_product;
  logic            fpm_overflow;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign sel_a = req_a[32*int'(grant_id) +: 32];
  assign sel_b = req_b[32*int'(grant_id) +: 32];

`ifdef FPM_ARB_ZERO_BYPASS_EN
  assign zero_hit = (sel_a[30:0] == 31'd0) || (sel_b[30:0] == 31'd0);
`else
  assign zero_hit = 1'b0;
`endif

  assign ptr_next = (op_id_p0 == ID_W'(NUM_REQ - 1)) ? '0 : op_id_p0 + ID_W'(1);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (rst && grant_vld) begin
          req_ready = NUM_REQ'(1) << grant_id;
          state_nxt = zero_hit ? RESP : EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operands captured at the grant edge
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) begin
      op_a_p0  <= sel_a;
      op_b_p0  <= sel_b;
      op_id_p0 <= grant_id;
    end
  end

  fpm_rr_scheduler_fpm u_fpm (
    .a        (op_a_p0),
    .b        (op_b_p0),
    .product  (fpm_product),
    .overflow (fpm_overflow)
  );

  // p1: result register, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_product  <= '0;
      resp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld && zero_hit) begin
            resp_valid    <= 1'b1;
            resp_id       <= grant_id;
            resp_product  <= {sel_a[31] ^ sel_b[31], 31'b0};
            resp_overflow <= 1'b0;
          end
        end
        EXEC: begin
          resp_valid    <= 1'b1;
          resp_id       <= op_id_p0;
          resp_product  <= fpm_product;
          resp_overflow <= fpm_overflow;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_rr_scheduler.sv
// Self-checking bench for fpm_rr_scheduler: directed scenarios plus randomized traffic
// against a transaction-level arbitration and float-multiply reference model.
module tb_fpm_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef FPM_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '1;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_product;
  logic                  resp_overflow;
  logic                  busy;
  logic [31:0]           ta [NUM_REQ];
  logic [31:0]           tbv[NUM_REQ];

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr   = 0;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_pack
    assign req_a[32*gi +: 32] = ta[gi];
    assign req_b[32*gi +: 32] = tbv[gi];
  end

  fpm_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .resp_overflow(resp_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // {overflow, product} from value arithmetic: exact integer mantissa product, then
  // round-half-even on the remainder, flush tiny results, saturate huge ones.
  function automatic logic [32:0] fpm_model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned m, q, rem, half;
    int e, sh;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'b0};
    m  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = (m >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {1'b1, s, 8'hff, 23'h0};
    if (e <= 0) return {1'b0, s, 31'b0};
    return {1'b0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0:       v[30:0]  = 31'd0;
      1:       v[30:23] = 8'd0;
      2, 3:    v[30:23] = 8'($urandom_range(190, 254));
      default: v[30:23] = 8'($urandom_range(20, 230));
    endcase
    return v;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
      n_total++; if ({resp_valid, busy} !== 2'b00) $display("FAIL reset_valid_busy got=%b exp=00", {resp_valid, busy}); else n_pass++;
      n_total++; if ({resp_id, resp_overflow, resp_product} !== 35'd0) $display("FAIL reset_resp got=%h exp=0", {resp_id, resp_overflow, resp_product}); else n_pass++;
    end
    req_valid = '0;
    rst = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    ta[0] = 32'h408a2000; tbv[0] = 32'hc08a2000;
    req_valid = 4'b0001; #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    n_total++; if ({resp_valid, busy} !== 2'b01) $display("FAIL single_exec got=%b exp=01", {resp_valid, busy}); else n_pass++;
    tick();
    n_total++; if ({resp_valid, resp_id, resp_overflow, resp_product} !== {1'b1, 2'd0, 1'b0, 32'hc1950d08})
      $display("FAIL single_resp got v=%b id=%0d ovf=%b p=%h exp v=1 id=0 ovf=0 p=c1950d08", resp_valid, resp_id, resp_overflow, resp_product);
    else n_pass++;
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    n_total++; if ({resp_valid, busy} !== 2'b00) $display("FAIL single_done got=%b exp=00", {resp_valid, busy}); else n_pass++;
    m_ptr = 1;
  endtask

  task automatic test_round_robin();
    logic [32:0] exp;
    int g;
    rst = 1'b0; tick(); rst = 1'b1; m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ta[i] = $urandom; tbv[i] = $urandom;
      ta[i][30:23] = 8'($urandom_range(100, 150)); tbv[i][30:23] = 8'($urandom_range(100, 150));
    end
    ta[2] = 32'hc28aa000; tbv[2] = 32'hc10a2000;
    resp_ready = 1'b1; req_valid = 4'b1111; #1;
    for (int n = 0; n < 5; n++) begin
      g = model_grant(req_valid, m_ptr);
      n_total++; if (req_ready !== (4'(1) << (n % NUM_REQ))) $display("FAIL rr_grant n=%0d got=%b exp_idx=%0d", n, req_ready, n % NUM_REQ); else n_pass++;
      exp = fpm_model(ta[g], tbv[g]);
      tick();
      n_total++; if ({resp_valid, busy, req_ready} !== 6'b010000) $display("FAIL rr_exec n=%0d got=%b exp=010000", n, {resp_valid, busy, req_ready}); else n_pass++;
      tick();
      n_total++; if ({resp_valid, resp_id, resp_overflow, resp_product} !== {1'b1, ID_W'(g), exp})
        $display("FAIL rr_resp n=%0d got v=%b id=%0d ovf=%b p=%h exp id=%0d ovf=%b p=%h", n, resp_valid, resp_id, resp_overflow, resp_product, g, exp[32], exp[31:0]);
      else n_pass++;
      if (g == 2) begin
        n_total++; if (resp_product !== 32'h44159728) $display("FAIL rr_req2_product got=%h exp=44159728", resp_product); else n_pass++;
      end
      tick();
      m_ptr = (g + 1) % NUM_REQ;
    end
    req_valid = '0; resp_ready = 1'b0;
    tick();
    m_ptr = 1;  // op 5 was requester 0
  endtask

  task automatic test_backpressure();
    logic [32:0] exp;
    int r;
    r = $urandom_range(0, NUM_REQ - 1);
    ta[r] = 32'h3fc00000; tbv[r] = 32'hc0400000;  // 1.5 * -3.0
    exp = fpm_model(ta[r], tbv[r]);
    req_valid = 4'(1) << r; #1;
    tick(); req_valid = '0;
    tick();
    req_valid = 4'b1111; #1;
    for (int c = 0; c <= 5; c++) begin
      n_total++; if ({resp_valid, busy, req_ready, resp_id, resp_overflow, resp_product} !== {2'b11, 4'b0000, ID_W'(r), exp})
        $display("FAIL bp_hold c=%0d got v=%b busy=%b rdy=%b id=%0d p=%h exp id=%0d p=%h", c, resp_valid, busy, req_ready, resp_id, resp_product, r, exp[31:0]);
      else n_pass++;
      ta[r] = $urandom; tbv[r] = $urandom;
      if (c < 5) tick();
    end
    n_total++; if (resp_product !== 32'hc0900000) $display("FAIL bp_product got=%h exp=c0900000", resp_product); else n_pass++;
    resp_ready = 1'b1; tick(); resp_ready = 1'b0; #1;
    m_ptr = (r + 1) % NUM_REQ;
    n_total++; if ({resp_valid, busy, req_ready} !== {2'b00, 4'(1) << model_grant(4'b1111, m_ptr)})
      $display("FAIL bp_release got=%b exp_grant=%0d", {resp_valid, busy, req_ready}, m_ptr);
    else n_pass++;
    req_valid = '0;
    tick();
  endtask

  task automatic test_zero();
    logic [31:0] av [2];
    av[0] = 32'h00000000; av[1] = 32'h80000000;
    for (int z = 0; z < 2; z++) begin
      ta[1] = av[z]; tbv[1] = 32'h418aa000;
      req_valid = 4'b0010; #1;
      n_total++; if (req_ready !== 4'b0010) $display("FAIL zero_ready got=%b exp=0010", req_ready); else n_pass++;
      tick(); req_valid = '0;
`ifdef FPM_ARB_ZERO_BYPASS_EN
      n_total++; if (resp_valid !== 1'b1) $display("FAIL zero_latency1 got=%b exp=1", resp_valid); else n_pass++;
`else
      n_total++; if (resp_valid !== 1'b0) $display("FAIL zero_latency2_early got=%b exp=0", resp_valid); else n_pass++;
      tick();
`endif
      n_total++; if ({resp_valid, resp_id, resp_overflow, resp_product} !== {1'b1, 2'd1, 1'b0, av[z][31], 31'b0})
        $display("FAIL zero_resp z=%0d got v=%b id=%0d ovf=%b p=%h exp p=%h", z, resp_valid, resp_id, resp_overflow, resp_product, {av[z][31], 31'b0});
      else n_pass++;
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      m_ptr = 2;
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] mask;
    logic [32:0] exp;
    logic [31:0] ag, bg;
    int g, lat, explat, hold;
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin ta[i] = rand_fp(); tbv[i] = rand_fp(); end
      mask = NUM_REQ'($urandom_range(0, 15));
      req_valid = mask; #1;
      if (mask == '0) begin
        n_total++; if ({busy, req_ready} !== 5'b0) $display("FAIL rnd_idle n=%0d got=%b exp=00000", n, {busy, req_ready}); else n_pass++;
        tick();
        continue;
      end
      g = model_grant(mask, m_ptr);
      n_total++; if (req_ready !== (4'(1) << g)) $display("FAIL rnd_grant n=%0d got=%b exp_idx=%0d", n, req_ready, g); else n_pass++;
      ag = ta[g]; bg = tbv[g];
      exp = fpm_model(ag, bg);
      explat = (BYP && (ag[30:0] == 31'd0 || bg[30:0] == 31'd0)) ? 1 : 2;
      tick();
      req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++) begin ta[i] = rand_fp(); tbv[i] = rand_fp(); end
      #1;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 4) begin
        n_total++; if ({busy, req_ready} !== 5'b10000) $display("FAIL rnd_busy n=%0d got=%b exp=10000", n, {busy, req_ready}); else n_pass++;
        tick(); lat++;
      end
      n_total++; if (lat !== explat) $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, lat, explat); else n_pass++;
      n_total++; if ({resp_id, resp_overflow, resp_product} !== {ID_W'(g), exp})
        $display("FAIL rnd_resp n=%0d a=%h b=%h got id=%0d ovf=%b p=%h exp id=%0d ovf=%b p=%h", n, ag, bg, resp_id, resp_overflow, resp_product, g, exp[32], exp[31:0]);
      else n_pass++;
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        tick();
        n_total++; if ({resp_valid, req_ready, resp_id, resp_overflow, resp_product} !== {1'b1, 4'b0000, ID_W'(g), exp})
          $display("FAIL rnd_hold n=%0d got v=%b rdy=%b p=%h exp p=%h", n, resp_valid, req_ready, resp_product, exp[31:0]);
        else n_pass++;
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      m_ptr = (g + 1) % NUM_REQ;
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_midop();
    ta[2] = 32'h3f800000; tbv[2] = 32'h40000000;
    req_valid = 4'b0100; #1;
    tick(); req_valid = '0;
    tick();
    n_total++; if ({resp_id, resp_product} !== {2'd2, 32'h40000000}) $display("FAIL midop_pre got id=%0d p=%h exp id=2 p=40000000", resp_id, resp_product); else n_pass++;
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    ta[1] = 32'h40400000; tbv[1] = 32'h40400000;
    req_valid = 4'b0010; #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL midop_grant got=%b exp=0010", req_ready); else n_pass++;
    tick(); req_valid = 4'b1111;
    rst = 1'b0; tick();
    n_total++; if ({resp_valid, busy, req_ready} !== 6'b0) $display("FAIL midop_reset got=%b exp=000000", {resp_valid, busy, req_ready}); else n_pass++;
    rst = 1'b1; req_valid = '0; #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++; if ({resp_valid, busy} !== 2'b00) $display("FAIL midop_noresp c=%0d got=%b exp=00", c, {resp_valid, busy}); else n_pass++;
    end
    req_valid = 4'b1010; #1;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL midop_ptr got=%b exp=0010", req_ready); else n_pass++;
    req_valid = '0;
    m_ptr = 0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin ta[i] = '0; tbv[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
